// File: rtl/apb_reg_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : apb_reg_slave
//  Description : APB slave exposing seven 32-bit read/write registers
//                (REG0..REG6 at 0x00..0x18) and a read-only write counter
//                WCOUNT at 0x1C that counts committed register writes.
//                WAIT_CYCLES (0..7) inserts extra access cycles before pready.
//
//  Ports       : hclk     - clock, rising edge active
//                hreset   - synchronous active-high reset
//                psel     - APB slave select
//                penable  - APB access phase
//                pwrite   - 1 = write, 0 = read
//                paddr    - 32-bit byte address
//                pwdata   - 32-bit write data
//                prdata   - 32-bit read data, non-zero only in a read pready cycle
//                pready   - transfer completes in this cycle
//                pslverr  - error response, valid with pready
//
//  Option      : define APB_REG_SLAVE_SLVERR_EN to flag out-of-range accesses
//                and writes to WCOUNT with pslverr; otherwise pslverr is 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_reg_slave #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam logic [2:0] c_WAIT_LOAD = 3'(WAIT_CYCLES);
    localparam int         c_NUM_RW    = 7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_wait_cnt;
    logic [31:0] r_regs [c_NUM_RW];
    logic [31:0] r_wcount;

    logic        w_in_range;
    logic [2:0]  w_idx;
    logic        w_access;
    logic        w_done;
    logic        w_wr_commit;
    logic [31:0] w_rd_val;

    // Address decode: word-aligned and within the 32-byte window.
    assign w_in_range = (paddr[31:5] == 27'd0) && (paddr[1:0] == 2'b00);
    assign w_idx      = paddr[4:2];

    // An access cycle counts only while the master holds psel and penable.
    assign w_access    = (r_state == S_ACCESS) && psel && penable;
    assign w_done      = w_access && (r_wait_cnt == 3'd0);

    // WCOUNT (index 7) is read-only; writes to it or out of range are dropped.
    assign w_wr_commit = w_done && pwrite && w_in_range && (w_idx != 3'd7);

    // ------------------------------------------------------------------------
    // Transfer FSM and wait counter
    // ------------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // psel with penable but no prior setup is ignored here.
                    if (psel && !penable) begin
                        r_state    <= S_ACCESS;
                        r_wait_cnt <= c_WAIT_LOAD;
                    end
                end
                S_ACCESS: begin
                    if (!psel) begin
                        // Master abandoned the transfer: nothing commits.
                        r_state <= S_IDLE;
                    end else if (!penable) begin
                        // A fresh setup restarts the wait sequence.
                        r_wait_cnt <= c_WAIT_LOAD;
                    end else if (r_wait_cnt != 3'd0) begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Back-to-back setup presented during the DONE cycle.
                    if (psel && !penable) begin
                        r_state    <= S_ACCESS;
                        r_wait_cnt <= c_WAIT_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wait_cnt <= 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Register file and write counter
    // ------------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (hreset) begin
            for (int i = 0; i < c_NUM_RW; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_wcount <= 32'd0;
        end else if (w_wr_commit) begin
            for (int i = 0; i < c_NUM_RW; i++) begin
                if (w_idx == 3'(i)) begin
                    r_regs[i] <= pwdata;
                end
            end
            r_wcount <= r_wcount + 32'd1;   // wraps naturally at 2^32
        end
    end

    // ------------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_val = 32'd0;
        if (w_in_range) begin
            if (w_idx == 3'd7) begin
                w_rd_val = r_wcount;
            end else begin
                for (int i = 0; i < c_NUM_RW; i++) begin
                    if (w_idx == 3'(i)) begin
                        w_rd_val = r_regs[i];
                    end
                end
            end
        end
    end

    assign pready = w_done;
    assign prdata = (w_done && !pwrite) ? w_rd_val : 32'd0;

`ifdef APB_REG_SLAVE_SLVERR_EN
    assign pslverr = w_done && (!w_in_range || (pwrite && (w_idx == 3'd7)));
`else
    assign pslverr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_apb_reg_slave
//  Description : Self-checking bench for apb_reg_slave. Three instances:
//                u_dut0 (WAIT_CYCLES=0), u_dut1 (3), u_dut2 (2), each with its
//                own bus so their states stay independent.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_reg_slave;

`ifdef APB_REG_SLAVE_SLVERR_EN
    localparam bit c_SE = 1'b1;
`else
    localparam bit c_SE = 1'b0;
`endif

    logic        hclk;
    logic [2:0]  hreset;
    logic [2:0]  psel;
    logic [2:0]  penable;
    logic [2:0]  pwrite;
    logic [31:0] paddr  [3];
    logic [31:0] pwdata [3];
    wire  [31:0] prdata [3];
    wire  [2:0]  pready;
    wire  [2:0]  pslverr;

    int n_tot = 0;
    int n_bad = 0;

    apb_reg_slave #(.WAIT_CYCLES(0)) u_dut0 (
        .hclk(hclk), .hreset(hreset[0]), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
    );
    apb_reg_slave #(.WAIT_CYCLES(3)) u_dut1 (
        .hclk(hclk), .hreset(hreset[1]), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
    );
    apb_reg_slave #(.WAIT_CYCLES(2)) u_dut2 (
        .hclk(hclk), .hreset(hreset[2]), .psel(psel[2]), .penable(penable[2]),
        .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]),
        .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One APB transfer; returns at 1ns after the completing edge, bus still driven.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic err, output int waits);
        @(negedge hclk);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pwdata[d] = wd;
        @(negedge hclk);
        penable[d] = 1'b1;
        waits = 0;
        #1;
        while (!pready[d] && waits < 20) begin
            waits++;
            @(negedge hclk);
            #1;
        end
        if (!pready[d]) begin
            n_tot++;
            n_bad++;
            $display("FAIL timeout dut%0d addr %h: pready never rose", d, addr);
        end
        rd  = prdata[d];
        err = pslverr[d];
        @(posedge hclk);
        #1;
    endtask

    task automatic idle(input int d);
        @(negedge hclk);
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w;

        hreset = 3'b111;
        psel = 3'b000; penable = 3'b000; pwrite = 3'b000;
        for (int i = 0; i < 3; i++) begin
            paddr[i] = 32'd0; pwdata[i] = 32'd0;
        end

        //            wr  addr           wdata          exp_rd         err
        vecs[0]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_001C, 32'h0,         32'h0000_0001, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0000, 32'hA5A5_0001, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0018, 32'h0000_0066, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0018, 32'h0,         32'h0000_0066, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0001, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_001C, 32'h0000_1234, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_001C, 32'h0,         32'h0000_0003, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0020, 32'h0,         32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, 32'h0000_0005, 32'h0,         32'h0000_0000, 1'b1};
        vecs[13] = '{1'b1, 32'h8000_0004, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[15] = '{1'b1, 32'h0000_0014, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
        vecs[16] = '{1'b0, 32'h0000_0014, 32'h0,         32'h0BAD_F00D, 1'b0};
        vecs[17] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b0};
        vecs[18] = '{1'b0, 32'h0000_001C, 32'h0,         32'h0000_0004, 1'b0};

        repeat (3) @(negedge hclk);
        hreset = 3'b000;
        #1;

        // Reset-state outputs
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset pready dut%0d", d),  {31'd0, pready[d]},  32'd0);
            check($sformatf("reset prdata dut%0d", d),  prdata[d],           32'd0);
            check($sformatf("reset pslverr dut%0d", d), {31'd0, pslverr[d]}, 32'd0);
        end

        // Table-driven single transfers, zero wait states
        for (int i = 0; i < 19; i++) begin
            xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, er, w);
            idle(0);
            check($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d pslverr", i), {31'd0, er}, {31'd0, vecs[i].exp_err & c_SE});
            check($sformatf("vec%0d waits", i), 32'(w), 32'd0);
        end

        // Back-to-back writes with setup in each DONE cycle
        xfer(0, 1'b1, 32'h08, 32'h0000_0011, rd, er, w);
        check("b2b w0 waits", 32'(w), 32'd0);
        xfer(0, 1'b1, 32'h0C, 32'h0000_0022, rd, er, w);
        check("b2b w1 waits", 32'(w), 32'd0);
        xfer(0, 1'b1, 32'h10, 32'h0000_0033, rd, er, w);
        check("b2b w2 waits", 32'(w), 32'd0);
        xfer(0, 1'b0, 32'h1C, 32'h0, rd, er, w);
        check("b2b wcount", rd, 32'd7);
        xfer(0, 1'b0, 32'h08, 32'h0, rd, er, w);
        check("b2b reg2", rd, 32'h0000_0011);
        xfer(0, 1'b0, 32'h0C, 32'h0, rd, er, w);
        check("b2b reg3", rd, 32'h0000_0022);
        xfer(0, 1'b0, 32'h10, 32'h0, rd, er, w);
        check("b2b reg4", rd, 32'h0000_0033);
        idle(0);

        // Three wait states
        xfer(1, 1'b0, 32'h00, 32'h0, rd, er, w);
        idle(1);
        check("w3 read waits", 32'(w), 32'd3);
        check("w3 read data", rd, 32'd0);
        xfer(1, 1'b1, 32'h0C, 32'h0000_0077, rd, er, w);
        idle(1);
        check("w3 write waits", 32'(w), 32'd3);
        xfer(1, 1'b0, 32'h0C, 32'h0, rd, er, w);
        idle(1);
        check("w3 readback", rd, 32'h0000_0077);
        check("w3 readback waits", 32'(w), 32'd3);

        // psel dropped during a wait cycle (WAIT_CYCLES=2)
        @(negedge hclk);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'h00; pwdata[2] = 32'h1234_5678;
        @(negedge hclk);
        penable[2] = 1'b1;
        #1;
        check("abort pready in wait", {31'd0, pready[2]}, 32'd0);
        @(negedge hclk);
        psel[2] = 1'b0; penable[2] = 1'b0;
        repeat (4) @(negedge hclk);
        #1;
        check("abort pready idle", {31'd0, pready[2]}, 32'd0);

        // Reset mid-access, then psel+penable without setup must be ignored
        @(negedge hclk);
        psel[2] = 1'b1; penable[2] = 1'b0;
        @(negedge hclk);
        penable[2] = 1'b1;
        @(negedge hclk);
        hreset[2] = 1'b1;
        @(negedge hclk);
        hreset[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("no-setup pready %0d", k), {31'd0, pready[2]}, 32'd0);
            @(negedge hclk);
        end
        psel[2] = 1'b0; penable[2] = 1'b0;

        xfer(2, 1'b0, 32'h00, 32'h0, rd, er, w);
        check("after abort reg0", rd, 32'd0);
        check("after abort waits", 32'(w), 32'd2);
        xfer(2, 1'b0, 32'h1C, 32'h0, rd, er, w);
        idle(2);
        check("after abort wcount", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 0, giving the number of extra access cycles before pready; the legal range is 0..7.
REQ-002 The block SHALL have port hclk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port hreset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port psel, input, 1 bit: APB slave select from the bridge.
REQ-005 The block SHALL have port penable, input, 1 bit: APB access-phase indicator.
REQ-006 The block SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-007 The block SHALL have port paddr, input, 32 bits: byte address.
REQ-008 The block SHALL have port pwdata, input, 32 bits: write data.
REQ-009 The block SHALL have port prdata, output, 32 bits: read data.
REQ-010 The block SHALL have port pready, output, 1 bit: transfer completes in this cycle.
REQ-011 The block SHALL have port pslverr, output, 1 bit: error response, valid only while pready=1.

Function
REQ-012 Register map SHALL be: REG0..REG6 read/write 32-bit at paddr 0x00..0x18 (index paddr[4:2]); REG7 at 0x1C is read-only WCOUNT.
REQ-013 An address SHALL be in range only if paddr[31:5]==0 and paddr[1:0]==0.
REQ-014 The FSM SHALL have states IDLE, ACCESS and DONE, encoded on 2 bits.
REQ-015 IDLE SHALL go to ACCESS when psel=1 and penable=0 (setup cycle), and load the wait counter with WAIT_CYCLES.
REQ-016 In ACCESS with psel=1 and penable=1, the block SHALL hold pready=0 and decrement the counter while it is non-zero.
REQ-017 pready SHALL be 1 in the access cycle where the counter is 0, so the first penable cycle completes when WAIT_CYCLES=0 (two-cycle APB transfer).
REQ-018 A write to REG0..REG6 SHALL commit on the rising edge that ends the pready=1 cycle.
REQ-019 On that same edge, WCOUNT SHALL increment by 1, wrapping from 0xFFFFFFFF to 0.
REQ-020 Read data SHALL drive prdata only while pready=1 and the access is a read; otherwise prdata SHALL be 0.
REQ-021 After completion the FSM SHALL enter DONE for one cycle with pready=0.
REQ-022 From DONE, the FSM SHALL go to ACCESS if psel=1 and penable=0 (back-to-back setup), else to IDLE.
REQ-023 If the completion cycle itself shows a new setup (psel=1, penable=0), that setup SHALL be honoured from DONE without loss.
REQ-024 If psel falls while in ACCESS before completion, the FSM SHALL return to IDLE with no register write and no WCOUNT change.
REQ-025 psel=1 with penable=1 seen in IDLE (no setup cycle) SHALL be ignored: no write, pready=0.
REQ-026 paddr, pwrite and pwdata SHALL be sampled in the completion cycle; changes during wait cycles are the master's protocol violation and need no special handling.
REQ-027 A write to WCOUNT or to an out-of-range address SHALL complete normally in timing and change no state.
REQ-028 A read from an out-of-range address SHALL return prdata=0.

Reset
REQ-029 When hreset=1 at a rising edge, the block SHALL set state to IDLE, REG0..REG6 to 0, WCOUNT to 0 and the wait counter to 0.
REQ-030 Output reset values SHALL be prdata=0, pready=0 and pslverr=0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no write; the first transfer after reset needs a fresh setup cycle.

Configuration
REQ-032 With macro APB_REG_SLAVE_SLVERR_EN defined, pslverr SHALL be 1 in the pready cycle of any out-of-range access or any write to WCOUNT, and 0 otherwise.
REQ-033 Without APB_REG_SLAVE_SLVERR_EN, pslverr SHALL be tied to 0, with all other behaviour unchanged.

Verification
REQ-034 WAIT_CYCLES=0, write 0xDEADBEEF to 0x04, then read 0x04 -> each transfer has pready=1 in the first penable cycle; the read returns 0xDEADBEEF; WCOUNT=1.
REQ-035 WAIT_CYCLES=3, read 0x00 -> pready=0 for 3 penable cycles, then 1 in the 4th with prdata=0 (reset value).
REQ-036 Three back-to-back writes to 0x08/0x0C/0x10 with a setup in each DONE cycle -> all three commit, then reading 0x1C returns 3.
REQ-037 With SLVERR_EN, write to 0x20 and write to 0x1C -> pslverr=1 in both pready cycles, WCOUNT unchanged, REG0..REG6 unchanged; without SLVERR_EN, pslverr stays 0.
REQ-038 Drop psel during a wait cycle, and separately assert hreset mid-access (WAIT_CYCLES=2), for a write of 0x12345678 to 0x00 -> FSM returns to IDLE; a later read of 0x00 returns 0 and WCOUNT=0.
